// File: rtl/udp_rx_depacketizer.sv
`default_nettype none
// ============================================================================
// Module      : udp_rx_depacketizer
// Description : Parses Ethernet/IPv4/UDP headers from an 8-bit MAC rx
//               stream, filters on local MAC/IP/port, and forwards only the
//               UDP payload with a correct last.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_rx_depacketizer #(
    parameter bit BCAST_EN  = 1'b1,
    parameter int HDR_BYTES = 42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] dst_port,
    input  logic [15:0] dst_port2,
    output logic        port_sel,
    output logic        frame_ok,
    output logic        frame_drop,
    output logic        frame_trunc,
    output logic [15:0] ok_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [5:0] c_hdrLast = 6'(HDR_BYTES - 1);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PAD     = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [5:0]  r_hdrCnt;
    logic        r_fail;
    logic        r_macUcast;
    logic        r_macBcast;
    logic        r_portHi0;
    logic        r_portHi1;
    logic        r_pendPort;
    logic [15:0] r_udpLen;
    logic [15:0] r_remain;
    logic        r_portSel;
    logic        r_frameOk;
    logic        r_frameDrop;
    logic        r_frameTrunc;
    logic [15:0] r_okCnt;
    logic [15:0] r_dropCnt;

    logic        w_hs;
    logic [7:0]  w_macByte;
    logic [7:0]  w_fieldByte;
    logic        w_fieldChk;
    logic        w_macUcastOk;
    logic        w_macBcastOk;
    logic        w_port0;
    logic        w_port1;
    logic [15:0] w_lenVal;
    logic        w_byteFail;
    logic        w_failAcc;
    logic        w_hdrDone;
    logic        w_payEnd;
    logic        w_okEvt;
    logic        w_dropEvt;
    logic        w_truncEvt;

    assign w_hs = in_valid & in_ready;

    // Expected constant/config byte for each checked header position
    always_comb begin
        w_macByte   = 8'h00;
        w_fieldByte = 8'h00;
        w_fieldChk  = 1'b0;
        case (r_hdrCnt)
            6'd0:  w_macByte = local_mac[47:40];
            6'd1:  w_macByte = local_mac[39:32];
            6'd2:  w_macByte = local_mac[31:24];
            6'd3:  w_macByte = local_mac[23:16];
            6'd4:  w_macByte = local_mac[15:8];
            6'd5:  w_macByte = local_mac[7:0];
            6'd12: begin w_fieldByte = 8'h08;          w_fieldChk = 1'b1; end
            6'd13: begin w_fieldByte = 8'h00;          w_fieldChk = 1'b1; end
            6'd14: begin w_fieldByte = 8'h45;          w_fieldChk = 1'b1; end
            6'd23: begin w_fieldByte = 8'h11;          w_fieldChk = 1'b1; end
            6'd30: begin w_fieldByte = local_ip[31:24]; w_fieldChk = 1'b1; end
            6'd31: begin w_fieldByte = local_ip[23:16]; w_fieldChk = 1'b1; end
            6'd32: begin w_fieldByte = local_ip[15:8];  w_fieldChk = 1'b1; end
            6'd33: begin w_fieldByte = local_ip[7:0];   w_fieldChk = 1'b1; end
            default: ;
        endcase
    end

    assign w_macUcastOk = ((r_hdrCnt == 6'd0) ? 1'b1 : r_macUcast) & (in_data == w_macByte);
    assign w_macBcastOk = ((r_hdrCnt == 6'd0) ? 1'b1 : r_macBcast) & (in_data == 8'hFF);
    assign w_port0      = r_portHi0 & (in_data == dst_port[7:0]);
    assign w_port1      = r_portHi1 & (in_data == dst_port2[7:0]);
    assign w_lenVal     = {r_udpLen[15:8], in_data};

    assign w_byteFail = ((r_hdrCnt == 6'd5) && !(w_macUcastOk || (BCAST_EN && w_macBcastOk)))
                      || (w_fieldChk && (in_data != w_fieldByte))
                      || ((r_hdrCnt == 6'd37) && !w_port0 && !w_port1)
                      || ((r_hdrCnt == 6'd39) && (w_lenVal < 16'd9));

    // Byte 0 starts a fresh frame, so stale failure state is ignored there
    assign w_failAcc = ((r_hdrCnt == 6'd0) ? 1'b0 : r_fail) | w_byteFail;
    assign w_hdrDone = (r_hdrCnt == c_hdrLast);
    assign w_payEnd  = (r_remain == 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b1;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_last    = 1'b0;
        w_okEvt     = 1'b0;
        w_dropEvt   = 1'b0;
        w_truncEvt  = 1'b0;
        case (r_state)
            ST_HDR: begin
                if (w_hs) begin
                    if (in_last) begin
                        w_dropEvt   = 1'b1;
                        w_nextState = ST_HDR;
                    end else if (w_hdrDone) begin
                        w_nextState = w_failAcc ? ST_DROP : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_data  = in_data;
                out_last  = in_valid & (w_payEnd | in_last);
                if (w_hs) begin
                    if (w_payEnd) begin
                        w_okEvt     = 1'b1;
                        w_nextState = in_last ? ST_HDR : ST_PAD;
                    end else if (in_last) begin
                        w_truncEvt  = 1'b1;
                        w_nextState = ST_HDR;
                    end
                end
            end
            ST_PAD: begin
                if (w_hs && in_last) begin
                    w_nextState = ST_HDR;
                end
            end
            ST_DROP: begin
                if (w_hs && in_last) begin
                    w_dropEvt   = 1'b1;
                    w_nextState = ST_HDR;
                end
            end
            default: w_nextState = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hdrCnt     <= 6'd0;
            r_fail       <= 1'b0;
            r_macUcast   <= 1'b0;
            r_macBcast   <= 1'b0;
            r_portHi0    <= 1'b0;
            r_portHi1    <= 1'b0;
            r_pendPort   <= 1'b0;
            r_udpLen     <= 16'd0;
            r_remain     <= 16'd0;
            r_portSel    <= 1'b0;
            r_frameOk    <= 1'b0;
            r_frameDrop  <= 1'b0;
            r_frameTrunc <= 1'b0;
            r_okCnt      <= 16'd0;
            r_dropCnt    <= 16'd0;
        end else begin
            r_frameOk    <= w_okEvt;
            r_frameDrop  <= w_dropEvt;
            r_frameTrunc <= w_truncEvt;
            if (w_okEvt) begin
                r_okCnt <= r_okCnt + 16'd1;
            end
            if (w_dropEvt || w_truncEvt) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
            if ((r_state == ST_HDR) && w_hs) begin
                r_hdrCnt   <= (in_last || w_hdrDone) ? 6'd0 : r_hdrCnt + 6'd1;
                r_fail     <= w_failAcc;
                r_macUcast <= w_macUcastOk;
                r_macBcast <= w_macBcastOk;
                if (r_hdrCnt == 6'd36) begin
                    r_portHi0 <= (in_data == dst_port[15:8]);
                    r_portHi1 <= (in_data == dst_port2[15:8]);
                end
                if (r_hdrCnt == 6'd37) begin
                    r_pendPort <= !w_port0 && w_port1;
                end
                if (r_hdrCnt == 6'd38) begin
                    r_udpLen[15:8] <= in_data;
                end
                if (r_hdrCnt == 6'd39) begin
                    r_udpLen[7:0] <= in_data;
                end
                if (w_hdrDone && !in_last && !w_failAcc) begin
                    r_remain  <= r_udpLen - 16'd8;
                    r_portSel <= r_pendPort;
                end
            end
            if ((r_state == ST_PAYLOAD) && w_hs && !w_payEnd) begin
                r_remain <= r_remain - 16'd1;
            end
        end
    end

    assign port_sel    = r_portSel;
    assign frame_ok    = r_frameOk;
    assign frame_drop  = r_frameDrop;
    assign frame_trunc = r_frameTrunc;
    assign ok_cnt      = r_okCnt;
    assign drop_cnt    = r_dropCnt;

endmodule
`default_nettype wire
